// File: rtl/sad_best_match.sv
// rtl/sad_best_match.sv - running minimum SAD search with early termination
// Tracks the best candidate of a search window and reports it on a one-cycle done pulse.
module sad_best_match #(
  parameter int WIDTH    = 8,
  parameter int SAD_W    = WIDTH + 5,
  parameter int NUM_CAND = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [SAD_W-1:0] early_thr,
  output logic             busy,
  output logic             done,
  output logic             early,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic [IDX_W:0]   cand_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  localparam logic [IDX_W:0]   LAST_CNT = (IDX_W + 1)'(NUM_CAND - 1);
  localparam logic [SAD_W-1:0] SAD_MAX  = '1;

  state_t           state_q, state_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [IDX_W:0]   cand_cnt_q, cand_cnt_d;
  logic [SAD_W-1:0] thr_q, thr_d;
  logic             early_q, early_d;

  logic             is_lower;
  logic             below_thr;

  // Strict compare keeps the earlier index on ties and never lets an all-ones SAD win.
  assign is_lower  = sad_in < best_sad_q;
  assign below_thr = (thr_q != '0) && (sad_in < thr_q);

  always_comb begin
    state_d    = state_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    cand_cnt_d = cand_cnt_q;
    thr_d      = thr_q;
    early_d    = early_q;

    if (start) begin
      state_d    = S_SEARCH;
      best_sad_d = SAD_MAX;
      best_idx_d = '0;
      cand_cnt_d = '0;
      thr_d      = early_thr;
      early_d    = 1'b0;
    end else begin
      case (state_q)
        S_SEARCH: begin
          if (sad_valid) begin
            if (is_lower) begin
              best_sad_d = sad_in;
              best_idx_d = cand_cnt_q[IDX_W-1:0];
            end
            cand_cnt_d = cand_cnt_q + 1'b1;
            // Threshold exit wins over window end when both hit on the last sample.
            if (below_thr) begin
              state_d = S_DONE;
              early_d = 1'b1;
            end else if (cand_cnt_q == LAST_CNT) begin
              state_d = S_DONE;
              early_d = 1'b0;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      best_sad_q <= SAD_MAX;
      best_idx_q <= '0;
      cand_cnt_q <= '0;
      thr_q      <= '0;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      cand_cnt_q <= cand_cnt_d;
      thr_q      <= thr_d;
      early_q    <= early_d;
    end
  end

  assign busy     = (state_q == S_SEARCH);
  assign done     = (state_q == S_DONE);
  assign early    = early_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;
  assign cand_cnt = cand_cnt_q;

endmodule

// File: tb/tb_sad_best_match.sv
// tb/tb_sad_best_match.sv - self-checking bench for sad_best_match
// Table vectors, randomized searches against a reference model, and abort/reset sequences.
module tb_sad_best_match;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sad_valid;
  logic [12:0] sad_in;
  logic [12:0] early_thr;
  logic        busy;
  logic        done;
  logic        early;
  logic [12:0] best_sad;
  logic [3:0]  best_idx;
  logic [4:0]  cand_cnt;

  int total = 0;
  int bad   = 0;

  sad_best_match dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sad_valid (sad_valid),
    .sad_in    (sad_in),
    .early_thr (early_thr),
    .busy      (busy),
    .done      (done),
    .early     (early),
    .best_sad  (best_sad),
    .best_idx  (best_idx),
    .cand_cnt  (cand_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0]       thr;
    logic [15:0][12:0] sads;
    int                gapmax;
    logic [12:0]       e_sad;
    logic [3:0]        e_idx;
    logic [4:0]        e_cnt;
    logic              e_early;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input logic [12:0] thr, input logic [15:0][12:0] s,
                                output logic [12:0] bs, output logic [3:0] bi,
                                output logic [4:0] cc, output logic er);
    bs = 13'h1FFF;
    bi = 4'd0;
    cc = 5'd0;
    er = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cc = 5'(k + 1);
      if (s[k] < bs) begin
        bs = s[k];
        bi = 4'(k);
      end
      if (thr != 13'd0 && s[k] < thr) begin
        er = 1'b1;
        break;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_search(input string name, input vec_t v);
    int   i, gap, cyc, busy_bad;
    logic seen;
    start     = 1'b1;
    early_thr = v.thr;
    sad_valid = 1'b0;
    tick();
    start     = 1'b0;
    early_thr = 13'd0;
    chk({name, " busy_at_start"}, int'(busy), 1);
    chk({name, " cnt_at_start"}, int'(cand_cnt), 0);
    i        = 0;
    cyc      = 0;
    busy_bad = 0;
    seen     = 1'b0;
    gap      = int'($urandom_range(0, v.gapmax));
    while (!seen && cyc < 200) begin
      if (gap == 0 && i < 16) begin
        sad_valid = 1'b1;
        sad_in    = v.sads[i];
        i++;
        gap = int'($urandom_range(0, v.gapmax));
      end else begin
        sad_valid = 1'b0;
        sad_in    = 13'($urandom);
        if (gap > 0) gap--;
      end
      tick();
      cyc++;
      if (done) seen = 1'b1;
      else if (!busy) busy_bad++;
    end
    chk({name, " done_seen"}, int'(seen), 1);
    chk({name, " busy_gaps"}, busy_bad, 0);
    chk({name, " samples_used"}, i, int'(v.e_cnt));
    chk({name, " best_sad"}, int'(best_sad), int'(v.e_sad));
    chk({name, " best_idx"}, int'(best_idx), int'(v.e_idx));
    chk({name, " cand_cnt"}, int'(cand_cnt), int'(v.e_cnt));
    chk({name, " early"}, int'(early), int'(v.e_early));
    chk({name, " busy_in_done"}, int'(busy), 0);
    // a sample offered while done is high must be ignored
    sad_valid = 1'b1;
    sad_in    = 13'd0;
    tick();
    sad_valid = 1'b0;
    chk({name, " done_one_cycle"}, int'(done), 0);
    chk({name, " idle_busy"}, int'(busy), 0);
    chk({name, " hold_sad"}, int'(best_sad), int'(v.e_sad));
    chk({name, " hold_cnt"}, int'(cand_cnt), int'(v.e_cnt));
  endtask

  vec_t tbl[7];
  int   s_full[16] = '{100, 90, 95, 40, 40, 70, 80, 120, 130, 140, 150, 160, 170, 180, 190, 200};

  initial begin
    int ndone;
    vec_t rv;

    rst       = 1'b0;
    start     = 1'b0;
    sad_valid = 1'b0;
    sad_in    = 13'd0;
    early_thr = 13'd0;
    #12;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst early", int'(early), 0);
    chk("rst best_sad", int'(best_sad), 8191);
    chk("rst best_idx", int'(best_idx), 0);
    chk("rst cand_cnt", int'(cand_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int t = 0; t < 7; t++) begin
      tbl[t].thr    = 13'd0;
      tbl[t].gapmax = 0;
      for (int k = 0; k < 16; k++) tbl[t].sads[k] = 13'd500;
    end
    for (int k = 0; k < 16; k++) tbl[0].sads[k] = 13'(s_full[k]);
    tbl[0].e_sad = 13'd40; tbl[0].e_idx = 4'd3; tbl[0].e_cnt = 5'd16; tbl[0].e_early = 1'b0;
    tbl[1].thr = 13'd20;
    tbl[1].sads[0] = 13'd300; tbl[1].sads[1] = 13'd150; tbl[1].sads[2] = 13'd12;
    tbl[1].e_sad = 13'd12; tbl[1].e_idx = 4'd2; tbl[1].e_cnt = 5'd3; tbl[1].e_early = 1'b1;
    for (int k = 0; k < 16; k++) tbl[2].sads[k] = 13'h1FFF;
    tbl[2].e_sad = 13'h1FFF; tbl[2].e_idx = 4'd0; tbl[2].e_cnt = 5'd16; tbl[2].e_early = 1'b0;
    tbl[3].thr = 13'd1;
    for (int k = 0; k < 15; k++) tbl[3].sads[k] = 13'd50;
    tbl[3].sads[15] = 13'd0;
    tbl[3].e_sad = 13'd0; tbl[3].e_idx = 4'd15; tbl[3].e_cnt = 5'd16; tbl[3].e_early = 1'b1;
    tbl[4] = tbl[0];
    tbl[4].gapmax = 3;
    tbl[5].thr = 13'h1FFF;
    tbl[5].sads[0] = 13'd5;
    tbl[5].e_sad = 13'd5; tbl[5].e_idx = 4'd0; tbl[5].e_cnt = 5'd1; tbl[5].e_early = 1'b1;
    for (int k = 0; k < 16; k++) tbl[6].sads[k] = 13'd7;
    tbl[6].e_sad = 13'd7; tbl[6].e_idx = 4'd0; tbl[6].e_cnt = 5'd16; tbl[6].e_early = 1'b0;

    for (int t = 0; t < 7; t++) run_search($sformatf("tbl%0d", t), tbl[t]);

    for (int r = 0; r < 25; r++) begin
      rv.thr    = ($urandom_range(0, 2) == 0) ? 13'd0 : 13'($urandom_range(1, 600));
      rv.gapmax = int'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++)
        rv.sads[k] = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 8191));
      model(rv.thr, rv.sads, rv.e_sad, rv.e_idx, rv.e_cnt, rv.e_early);
      run_search($sformatf("rnd%0d", r), rv);
    end

    // abort: restart with a colliding sample, then start again while done is high
    ndone     = 0;
    start     = 1'b1;
    early_thr = 13'd0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      sad_valid = 1'b1;
      sad_in    = (k == 2) ? 13'd3 : 13'd60;
      tick();
      if (done) ndone++;
    end
    chk("abort pre_cnt", int'(cand_cnt), 7);
    chk("abort pre_sad", int'(best_sad), 3);
    start  = 1'b1;
    sad_in = 13'd1;
    tick();
    start = 1'b0;
    chk("abort cleared_cnt", int'(cand_cnt), 0);
    chk("abort cleared_sad", int'(best_sad), 8191);
    chk("abort busy", int'(busy), 1);
    for (int k = 0; k < 16; k++) begin
      sad_valid = 1'b1;
      sad_in    = (k == 9) ? 13'd5 : 13'(40 + k);
      tick();
      if (done) ndone++;
    end
    sad_valid = 1'b0;
    chk("abort done", int'(done), 1);
    chk("abort best_idx", int'(best_idx), 9);
    chk("abort best_sad", int'(best_sad), 5);
    chk("abort cand_cnt", int'(cand_cnt), 16);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (done) ndone++;
    chk("abort done_count", ndone, 1);
    chk("restart_from_done busy", int'(busy), 1);
    chk("restart_from_done cnt", int'(cand_cnt), 0);

    // asynchronous reset in the middle of a search
    for (int k = 0; k < 5; k++) begin
      sad_valid = 1'b1;
      sad_in    = 13'(10 + k);
      tick();
    end
    sad_valid = 1'b0;
    chk("midrst pre_cnt", int'(cand_cnt), 5);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst early", int'(early), 0);
    chk("midrst best_sad", int'(best_sad), 8191);
    chk("midrst best_idx", int'(best_idx), 0);
    chk("midrst cand_cnt", int'(cand_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midrst no_done", int'(done), 0);
    chk("midrst idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
